// File: rtl/design_28_result_buf.sv
// rtl/design_28_result_buf.sv - result capture FIFO with overflow drop counter and running accumulator
//
// Purpose:
//   Captures results from an upstream producer that cannot be stalled. Accepted
//   results are queued in a small circular FIFO and presented first-word
//   fall-through to a downstream consumer. Results arriving while the FIFO is
//   full (and not being drained in the same cycle) are discarded and counted.
//   Every accepted result is also added into a wide running sum.
//
// Ports:
//   clk        in   1       clock, all state updates on rising edge
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       upstream result strobe (no backpressure)
//   in_data    in   W       upstream result value
//   out_valid  out  1       head entry available (== !empty)
//   out_ready  in   1       downstream accepts head entry
//   out_data   out  W       head entry value, read from storage
//   count      out  AW+1    current occupancy
//   full       out  1       count == DEPTH
//   empty      out  1       count == 0
//   drop_cnt   out  8       saturating count of results lost to overflow
//   acc        out  W+8     wrapping sum of all accepted results

module design_28_result_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic [7:0]                   drop_cnt,
    output logic [W+7:0]                 acc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage is intentionally not reset; its contents are only observed
    // through out_data while out_valid is high.
    logic [W-1:0]   mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic [7:0]     drop_q,   drop_d;
    logic [W+7:0]   acc_q,    acc_d;

    logic full_w;
    logic empty_w;
    logic pop;
    logic push;
    logic drop;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A pop frees the head slot at this edge, so a full FIFO can still accept
    // a push in the same cycle. When full, wr_ptr == rd_ptr, so the write
    // lands in the slot being vacated; the head value has already been
    // presented for this cycle, so overwriting it at the edge is safe.
    assign pop  = !empty_w && out_ready;
    assign push = in_valid && (!full_w || pop);
    assign drop = in_valid && full_w && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        acc_d    = acc_q;

        // DEPTH is a power of two, so pointer wrap from DEPTH-1 to 0 is the
        // natural overflow of an AW-bit increment.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            acc_d    = acc_q + {8'd0, in_data};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Control state: reset wins over any concurrent push/pop/drop, which also
    // makes in_valid during reset a no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            acc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            acc_q    <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = !empty_w;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign drop_cnt  = drop_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_design_28_result_buf.sv
// tb/tb_design_28_result_buf.sv - scoreboard testbench for design_28_result_buf

module tb_design_28_result_buf;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic [7:0]    drop_cnt;
    logic [W+7:0]  acc;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  sb_q[$];
    logic [7:0]    m_drop;
    logic [W+7:0]  m_acc;

    design_28_result_buf #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = sb_q.size();
        check_val("count", 32'(count), 32'(sz));
        check_val("out_valid", 32'(out_valid), 32'(sz != 0));
        check_val("empty", 32'(empty), 32'(sz == 0));
        check_val("full", 32'(full), 32'(sz == DEPTH));
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        check_val("acc", 32'(acc), 32'(m_acc));
        if (sz != 0) check_val("head", 32'(out_data), 32'(sb_q[0]));
    endtask

    // One clock: inputs applied 1ns after a rising edge, model updated, then
    // outputs compared 1ns after the next rising edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        int  sz;
        logic mpop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        sz   = sb_q.size();
        mpop = r && (sz != 0);
        if (mpop) begin
            check_val("pop_data", 32'(out_data), 32'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (v) begin
            if (sz < DEPTH || mpop) begin
                sb_q.push_back(d);
                m_acc = m_acc + {8'd0, d};
            end else if (m_drop != 8'hFF) begin
                m_drop = m_drop + 8'd1;
            end
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset(input logic v, input logic r);
        rst       = 1'b1;
        in_valid  = v;
        in_data   = 16'hBEEF;
        out_ready = r;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sb_q.delete();
        m_drop = '0;
        m_acc  = '0;
        check_status();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_drop = '0; m_acc = '0;
        @(posedge clk);
        #1;

        do_reset(1'b0, 1'b0);

        // Single push, first-word fall-through latency
        cycle(1'b1, 16'h1234, 1'b0);
        check_val("single_out_data", 32'(out_data), 32'h1234);
        check_val("single_acc", 32'(acc), 32'h001234);

        // Fill and overflow, then drain in order, then pop attempt on empty
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, W'(i), 1'b0);
        check_val("ovf_full", 32'(full), 32'd1);
        check_val("ovf_drop", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check_val("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, '0, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0);
        cycle(1'b1, 16'd9, 1'b1);
        check_val("fullpp_count", 32'(count), 32'd4);
        check_val("fullpp_drop", 32'(drop_cnt), 32'd1);
        // Stall with data present: head must hold
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        // Wrap-around at occupancy 1
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 16'd0, 1'b0);
        for (int i = 1; i <= 9; i++) cycle(1'b1, W'(i), 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Drop counter saturation
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 304; i++) cycle(1'b1, W'(i), 1'b0);
        check_val("drop_sat", 32'(drop_cnt), 32'd255);

        // Accumulator wrap
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 257; i++) cycle(1'b1, 16'hFFFF, 1'b1);
        check_val("acc_wrap", 32'(acc), 32'h00FEFF);

        // Reset mid-operation with push and pop requested
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'hA0 + i), 1'b0);
        check_val("pre_rst_count", 32'(count), 32'd3);
        do_reset(1'b1, 1'b1);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_acc", 32'(acc), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/design_28_result_buf.md
DESIGN_28_RESULT_BUF -- requirements
Module: design_28_result_buf

Interface
REQ-001 Parameter W, default 16, data width of captured results.
REQ-002 Parameter DEPTH, default 4, number of buffer entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream result strobe; no backpressure to upstream.
REQ-006 in_data  input  W  upstream result value, sampled when in_valid=1.
REQ-007 out_valid  output  1  head entry available.
REQ-008 out_ready  input  1  downstream accepts head entry.
REQ-009 out_data  output  W  head entry value.
REQ-010 count  output  log2(DEPTH)+1  current occupancy.
REQ-011 full  output  1  count==DEPTH.
REQ-012 empty  output  1  count==0.
REQ-013 drop_cnt  output  8  number of results lost to overflow; saturating.
REQ-014 acc  output  W+8  running sum of all accepted results; wraps modulo 2^(W+8).

Function
REQ-015 Buffer SHALL be a circular FIFO with write pointer, read pointer and occupancy counter.
REQ-016 pop SHALL occur when out_valid=1 and out_ready=1; head advances one entry.
REQ-017 push SHALL occur when in_valid=1 and (full=0 or pop in same cycle); in_data written at write pointer.
REQ-018 in_valid=1 with full=1 and no pop: in_data discarded, drop_cnt increments by 1, saturating at 255; FIFO contents unchanged.
REQ-019 Simultaneous push and pop: count unchanged, both pointers advance; valid at any occupancy including 1 and DEPTH.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 out_valid SHALL equal !empty; out_data SHALL be the head entry (first-word fall-through), driven from registered storage.
REQ-022 Latency: data pushed in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1 when FIFO was empty at N.
REQ-023 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 out_ready=1 with empty=1: no pop, no state change.
REQ-025 acc SHALL add zero-extended in_data on every push (not on drops), updated the cycle after the push.
REQ-026 Ordering SHALL be strict FIFO; no entry duplicated or skipped.

Reset
REQ-027 rst=1 at a rising edge SHALL clear pointers, count, drop_cnt and acc; outputs next cycle: out_valid=0, empty=1, full=0, count=0, drop_cnt=0, acc=0.
REQ-028 Storage array contents need not be reset; out_data value is don't-care while out_valid=0.
REQ-029 rst SHALL take priority over simultaneous push/pop; in-flight entries are discarded.
REQ-030 in_valid during the reset cycle SHALL be ignored (no push, no drop count).

Verification
REQ-031 Single push: rst then in_valid=1, in_data=0x1234, out_ready=0 -> next cycle out_valid=1, out_data=0x1234, count=1, acc=0x001234.
REQ-032 Fill and overflow (DEPTH=4): push 1,2,3,4,5 with out_ready=0 -> full=1, count=4, drop_cnt=1; then out_ready=1 drains 1,2,3,4 in order, empty=1.
REQ-033 Full with simultaneous pop: full, in_valid=1 data=9, out_ready=1 -> count stays 4, drop_cnt unchanged, 9 emerges after three earlier entries.
REQ-034 Wrap-around: 10 push/pop pairs of values 0..9 at occupancy 1 -> outputs 0..9 in order, count never exceeds 2.
REQ-035 Saturation/wrap: 300 pushes while full and stalled -> drop_cnt=255; 257 accepted pushes of 0xFFFF (W=16) -> acc=(257*0xFFFF) mod 2^24.
REQ-036 Reset mid-operation: count=3, assert rst with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, drop_cnt=0, acc=0.
